// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2
    } owner_e;

    // Owner of the read launched this cycle; writes and idle cycles return nothing.
    function automatic owner_e read_owner(input logic c_gnt, input logic c_we,
                                          input logic d_gnt, input logic d_we);
        owner_e own;
        if (c_gnt && !c_we) begin
            own = CORE;
        end else if (d_gnt && !d_we) begin
            own = DBG;
        end else begin
            own = NONE;
        end
        return own;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Saturating count of consecutive cycles the debug requester was denied.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         at_limit
);

    logic [W-1:0] count_r;

    // Clear has priority over increment; the count never passes the limit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r < limit)) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign at_limit = (count_r == limit);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/debug arbiter for the single-port data memory: zero-latency grant,
// command mux, one-cycle read return routing and bounded debug starvation.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout,
    output logic              core_stall
);

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    owner_e            owner_r;
    logic              c_gnt_s;
    logic              d_gnt_s;
    logic              wait_inc_s;
    logic              wait_clr_s;
    logic              wait_at_limit_s;
    logic [CNT_W-1:0]  wait_cnt_s;
    logic              m_we_s;
    logic [ADDR_W-1:0] m_addr_s;
    logic [DATA_W-1:0] m_din_s;

    // Counting only happens while arbitrating; lock ownership keeps it at zero.
    assign wait_inc_s = d_req & ~d_gnt_s & (state_r == ARB);
    assign wait_clr_s = d_gnt_s | ~d_req | (state_r == LOCK);

    arb_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (wait_inc_s),
        .clr      (wait_clr_s),
        .limit    (WAIT_LIMIT),
        .count    (wait_cnt_s),
        .at_limit (wait_at_limit_s)
    );

    // Grant selection: starved debug first, then core, then debug; lock is debug-only.
    always_comb begin
        c_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst) begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (state_r == LOCK) begin
            d_gnt_s = d_req;
        end else if (d_req && wait_at_limit_s) begin
            d_gnt_s = 1'b1;
        end else if (c_req) begin
            c_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            c_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Lock is entered by a debug grant with d_lock and left as soon as d_lock drops.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB: begin
                if (d_gnt_s && d_lock) begin
                    state_nxt_s = LOCK;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            LOCK: begin
                if (!d_lock) begin
                    state_nxt_s = ARB;
                end else begin
                    state_nxt_s = LOCK;
                end
            end
            default: state_nxt_s = ARB;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Memory command taken from whichever requester holds the grant; idle bus is all zero.
    always_comb begin
        m_we_s   = 1'b0;
        m_addr_s = {ADDR_W{1'b0}};
        m_din_s  = {DATA_W{1'b0}};
        if (c_gnt_s) begin
            m_we_s   = c_we;
            m_addr_s = c_addr;
            m_din_s  = c_wdata;
        end else if (d_gnt_s) begin
            m_we_s   = d_we;
            m_addr_s = d_addr;
            m_din_s  = d_wdata;
        end else begin
            m_we_s   = 1'b0;
            m_addr_s = {ADDR_W{1'b0}};
            m_din_s  = {DATA_W{1'b0}};
        end
    end

    // Remember who launched a read so next cycle's m_dout goes to the right place.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r <= NONE;
        end else begin
            owner_r <= read_owner(c_gnt_s, c_we, d_gnt_s, d_we);
        end
    end

    assign c_gnt      = c_gnt_s;
    assign d_gnt      = d_gnt_s;
    assign m_en       = c_gnt_s | d_gnt_s;
    assign m_we       = m_we_s;
    assign m_addr     = m_addr_s;
    assign m_din      = m_din_s;
    assign core_stall = rst & c_req & ~c_gnt_s;
    assign c_rvalid   = rst & (owner_r == CORE);
    assign d_rvalid   = rst & (owner_r == DBG);
    assign c_rdata    = m_dout;
    assign d_rdata    = m_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a cycle-level reference model.
module tb_dmem_port_arbiter;

    localparam int MW = 4;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we, core_stall;
    logic [31:0] c_rdata, d_rdata, m_addr, m_din, m_dout;

    int          n_vec;
    int          n_err;

    logic [31:0] env_mem [0:255];
    logic [31:0] ref_mem [0:255];

    int          md_wait;
    logic        md_lock;
    int          md_pend;
    logic [31:0] md_rdata;

    dmem_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .c_req      (c_req),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_gnt      (c_gnt),
        .c_rvalid   (c_rvalid),
        .c_rdata    (c_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_lock     (d_lock),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_din      (m_din),
        .m_dout     (m_dout),
        .core_stall (core_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (m_en && m_we) env_mem[m_addr[9:2]] <= m_din;
        if (m_en && !m_we) m_dout <= env_mem[m_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decide the grant from the arbitration rules, compare, then advance.
    always @(negedge clk) begin : model_cmp
        logic        e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_stall;
        logic [31:0] e_addr, e_din;
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (rst) begin
            if (md_lock) e_dg = d_req;
            else if (d_req && md_wait == MW) e_dg = 1'b1;
            else if (c_req) e_cg = 1'b1;
            else if (d_req) e_dg = 1'b1;
        end
        e_stall = rst & c_req & ~e_cg;
        e_en    = e_cg | e_dg;
        e_we    = e_cg ? c_we    : (e_dg ? d_we    : 1'b0);
        e_addr  = e_cg ? c_addr  : (e_dg ? d_addr  : 32'h0);
        e_din   = e_cg ? c_wdata : (e_dg ? d_wdata : 32'h0);
        e_crv   = rst && (md_pend == 1);
        e_drv   = rst && (md_pend == 2);

        check("c_gnt", {31'b0, c_gnt}, {31'b0, e_cg});
        check("d_gnt", {31'b0, d_gnt}, {31'b0, e_dg});
        check("excl_gnt", {31'b0, c_gnt & d_gnt}, 32'h0);
        check("core_stall", {31'b0, core_stall}, {31'b0, e_stall});
        check("m_en", {31'b0, m_en}, {31'b0, e_en});
        check("m_we", {31'b0, m_we}, {31'b0, e_we});
        check("m_addr", m_addr, e_addr);
        check("m_din", m_din, e_din);
        check("c_rvalid", {31'b0, c_rvalid}, {31'b0, e_crv});
        check("d_rvalid", {31'b0, d_rvalid}, {31'b0, e_drv});
        if (e_crv) check("c_rdata", c_rdata, md_rdata);
        if (e_drv) check("d_rdata", d_rdata, md_rdata);

        if (!rst) begin
            md_wait = 0;
            md_lock = 1'b0;
            md_pend = 0;
        end else begin
            if (e_en && e_we) ref_mem[e_addr[9:2]] = e_din;
            if (e_en && !e_we) begin
                md_pend  = e_cg ? 1 : 2;
                md_rdata = ref_mem[e_addr[9:2]];
            end else begin
                md_pend = 0;
            end
            if (md_lock || e_dg || !d_req) md_wait = 0;
            else if (md_wait < MW) md_wait = md_wait + 1;
            md_lock = md_lock ? d_lock : (e_dg & d_lock);
        end
    end

    task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                          input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                          input logic dl);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        md_wait = 0;
        md_lock = 1'b0;
        md_pend = 0;
        md_rdata = 32'h0;
        m_dout = 32'h0;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'hA500_0000 + i;
            ref_mem[i] = 32'hA500_0000 + i;
        end
        env_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;

        // Reset with both requesters active: every output must stay low.
        rst = 1'b0;
        set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1);
        mid();
        check("rst_c_gnt", {31'b0, c_gnt}, 32'h0);
        check("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
        check("rst_m_en", {31'b0, m_en}, 32'h0);
        check("rst_stall", {31'b0, core_stall}, 32'h0);
        nxt();
        idle();
        nxt();
        rst = 1'b1;

        // Core read of 0x10.
        set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("cr_gnt", {31'b0, c_gnt}, 32'h1);
        check("cr_m_en", {31'b0, m_en}, 32'h1);
        check("cr_m_addr", m_addr, 32'h10);
        nxt();
        idle();
        mid();
        check("cr_rvalid", {31'b0, c_rvalid}, 32'h1);
        check("cr_rdata", c_rdata, 32'hDEAD_BEEF);
        check("cr_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        nxt();

        // Contention: debug is forced in on the fifth cycle.
        for (int k = 0; k < 6; k++) begin
            set_in(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
            mid();
            if (k == 4) begin
                check("ct_d_gnt", {31'b0, d_gnt}, 32'h1);
                check("ct_stall", {31'b0, core_stall}, 32'h1);
            end else begin
                check("ct_c_gnt", {31'b0, c_gnt}, 32'h1);
                check("ct_nostall", {31'b0, core_stall}, 32'h0);
            end
            nxt();
        end
        idle();
        nxt();

        // Debug lock: three writes, plus a lock cycle without a request.
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h1, 1'b1);
        mid();
        check("lk_gnt0", {31'b0, d_gnt}, 32'h1);
        nxt();
        set_in(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        mid();
        check("lk_noreq_c_gnt", {31'b0, c_gnt}, 32'h0);
        check("lk_noreq_stall", {31'b0, core_stall}, 32'h1);
        nxt();
        set_in(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 32'h4, 32'h2, 1'b1);
        mid();
        check("lk_c_gnt1", {31'b0, c_gnt}, 32'h0);
        check("lk_d_gnt1", {31'b0, d_gnt}, 32'h1);
        nxt();
        set_in(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 32'h8, 32'h3, 1'b0);
        mid();
        check("lk_c_gnt2", {31'b0, c_gnt}, 32'h0);
        check("lk_stall2", {31'b0, core_stall}, 32'h1);
        check("lk_d_gnt2", {31'b0, d_gnt}, 32'h1);
        nxt();
        set_in(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("lk_release", {31'b0, c_gnt}, 32'h1);
        nxt();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        nxt();
        idle();
        mid();
        check("lk_readback", d_rdata, 32'h2);
        nxt();

        // Back-to-back mixed traffic.
        set_in(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        nxt();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        mid();
        check("mx_c_rvalid", {31'b0, c_rvalid}, 32'h1);
        check("mx_c_rdata", c_rdata, 32'hA500_0008);
        nxt();
        set_in(1'b1, 1'b1, 32'h28, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        mid();
        check("mx_d_rvalid", {31'b0, d_rvalid}, 32'h1);
        check("mx_d_rdata", d_rdata, 32'hA500_0009);
        check("mx_c_rv_off", {31'b0, c_rvalid}, 32'h0);
        nxt();
        idle();
        mid();
        check("mx_wr_norv", {31'b0, c_rvalid | d_rvalid}, 32'h0);
        nxt();

        // Reset mid-read after a partial starvation build-up.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 1'b0);
            nxt();
        end
        set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 1'b0);
        mid();
        check("rs_c_gnt", {31'b0, c_gnt}, 32'h1);
        nxt();
        rst = 1'b0;
        idle();
        mid();
        check("rs_c_rvalid", {31'b0, c_rvalid}, 32'h0);
        check("rs_m_en", {31'b0, m_en}, 32'h0);
        nxt();
        rst = 1'b1;
        set_in(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 1'b0);
        mid();
        check("rs_post_c_gnt", {31'b0, c_gnt}, 32'h1);
        nxt();
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 1'b1);
        nxt();
        rst = 1'b0;
        idle();
        mid();
        check("rs_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        nxt();
        rst = 1'b1;
        set_in(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h54, 32'h0, 1'b0);
        mid();
        check("rs_unlock_c_gnt", {31'b0, c_gnt}, 32'h1);
        nxt();
        idle();
        nxt();

        // Idle stretch.
        for (int k = 0; k < 10; k++) begin
            idle();
            mid();
            check("id_m_en", {31'b0, m_en}, 32'h0);
            check("id_m_addr", m_addr, 32'h0);
            check("id_rvalid", {31'b0, c_rvalid | d_rvalid}, 32'h0);
            check("id_stall", {31'b0, core_stall}, 32'h0);
            nxt();
        end

        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
